// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32I opcode/funct3 constants and immediate-format
// selection used by the issue decoder and its immediate generator.
package alu_pkg;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] SLL  = 4'b0010;
    localparam logic [3:0] SLT  = 4'b0100;
    localparam logic [3:0] MOV  = 4'b0101;
    localparam logic [3:0] SLTU = 4'b0110;
    localparam logic [3:0] EXOR = 4'b1000;
    localparam logic [3:0] SRL  = 4'b1010;
    localparam logic [3:0] SRA  = 4'b1011;
    localparam logic [3:0] ORR  = 4'b1100;
    localparam logic [3:0] AND  = 4'b1110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate extraction; the format is picked from the
// opcode and the result is sign-extended from instr[31] to WIDTH.
module riscv_imm_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    output logic [WIDTH-1:0] imm
);

    logic sign;
    assign sign = instr[31];

    always_comb begin
        imm = '0;
        case (imm_format(instr[6:0]))
            IMM_I: imm = {{(WIDTH-12){sign}}, instr[31:20]};
            IMM_S: imm = {{(WIDTH-12){sign}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(WIDTH-12){sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {{(WIDTH-31){sign}}, instr[30:12], 12'b0};
            IMM_J: imm = {{(WIDTH-20){sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// Registered RV32I decode/issue stage producing ALU control, operands and immediate.
// Define ALU_ISSUE_SKID_EN for a 2-entry (output + skid) buffer; otherwise a single register.
module alu_issue_decoder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_control,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_imm,
    output logic [4:0]       out_rd,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_illegal
);

    localparam int ENTRY_W = 1 + 4 + 5 + 4 * WIDTH;

    logic [6:0]       opcode;
    logic [4:0]       rd_field;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             is_srai;
    logic [WIDTH-1:0] gen_imm;

    logic [3:0]       dec_control;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;
    logic [WIDTH-1:0] dec_imm;
    logic [4:0]       dec_rd;
    logic             dec_illegal;
    logic [ENTRY_W-1:0] in_entry;

    logic               out_valid_reg;
    logic [ENTRY_W-1:0] out_entry_reg;

    assign opcode   = in_instr[6:0];
    assign rd_field = in_instr[11:7];
    assign f3       = in_instr[14:12];
    assign f7       = in_instr[31:25];
    assign is_srai  = (f3 == 3'b101) && (f7 == 7'b0100000);

    riscv_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr (in_instr),
        .imm   (gen_imm)
    );

    always_comb begin
        dec_control = ADD;
        dec_a       = '0;
        dec_b       = '0;
        dec_imm     = gen_imm;
        dec_rd      = rd_field;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a       = in_rs1;
                dec_b       = in_rs2;
                dec_control = {f3, f7[5]};
                if ((f7 != 7'b0000000 && f7 != 7'b0100000) ||
                    (f7[5] && f3 != 3'b000 && f3 != 3'b101))
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                // imm[11:5] overlaps funct7; only SRAI may carry the bit5 code
                dec_a       = in_rs1;
                dec_b       = gen_imm;
                dec_control = {f3, is_srai};
                if ((f3 == 3'b001 && f7 != 7'b0000000) ||
                    (f3 == 3'b101 && f7 != 7'b0000000 && !is_srai))
                    dec_illegal = 1'b1;
            end
            OPC_LUI: begin
                dec_control = MOV;
                dec_b       = gen_imm;
            end
            OPC_AUIPC, OPC_JAL: begin
                dec_a = in_pc;
                dec_b = gen_imm;
            end
            OPC_JALR, OPC_LOAD: begin
                dec_a = in_rs1;
                dec_b = gen_imm;
            end
            OPC_STORE: begin
                dec_a  = in_rs1;
                dec_b  = gen_imm;
                dec_rd = 5'd0;
            end
            OPC_BRANCH: begin
                dec_a  = in_rs1;
                dec_b  = in_rs2;
                dec_rd = 5'd0;
                case (f3)
                    F3_BEQ, F3_BNE:   dec_control = SUB;
                    F3_BLT, F3_BGE:   dec_control = SLT;
                    F3_BLTU, F3_BGEU: dec_control = SLTU;
                    default:          dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal entries still issue so the fault is reported, but carry no operands
        if (dec_illegal) begin
            dec_control = ADD;
            dec_a       = '0;
            dec_b       = '0;
            dec_imm     = '0;
            dec_rd      = 5'd0;
        end
    end

    assign in_entry = {dec_illegal, dec_control, dec_rd, in_pc, dec_imm, dec_a, dec_b};

`ifdef ALU_ISSUE_SKID_EN
    logic               skid_valid_reg;
    logic [ENTRY_W-1:0] skid_entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_entry_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_entry_reg <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!out_valid_reg || out_ready) begin
            // Output slot frees this edge: an older skid entry always goes first
            if (skid_valid_reg) begin
                out_entry_reg  <= skid_entry_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= in_valid;
                if (in_valid)
                    out_entry_reg <= in_entry;
            end
        end else if (in_valid && !skid_valid_reg) begin
            skid_entry_reg <= in_entry;
            skid_valid_reg <= 1'b1;
        end
    end

    assign in_ready = ~skid_valid_reg;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_entry_reg <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (in_ready) begin
            out_valid_reg <= in_valid;
            if (in_valid)
                out_entry_reg <= in_entry;
        end
    end

    assign in_ready = ~out_valid_reg | out_ready;
`endif

    assign out_valid = out_valid_reg;
    assign {out_illegal, out_control, out_rd, out_pc, out_imm, out_a, out_b} = out_entry_reg;

endmodule
